// File: rtl/lsu_route_ctrl_pkg.sv
// Shared types and defaults for the load/store routing controller.
package lsu_route_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_IO   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [31:0] DEF_IO_BASE      = 32'h1000_0000;
    localparam logic [31:0] DEF_IO_MASK      = 32'hF000_0000;
    localparam int          DEF_TIMEOUT      = 16;
    localparam logic [31:0] TIMEOUT_ERR_DATA = 32'h0000_0000;

    function automatic logic addr_is_io(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/lsu_route_ctrl_if.sv
// Core request, memory and MMIO signals of the load/store routing controller.
interface lsu_route_ctrl_if;

    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        cpu_stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        bus_err;
    logic        route_sel;
    logic [31:0] wdata_out;
    logic [31:0] addr_out;
    logic [3:0]  wstrb_out;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        io_valid;
    logic        io_we;
    logic        io_ready;
    logic [31:0] io_rdata;

    // The controller side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  mem_rdata, io_ready, io_rdata,
        output cpu_stall, resp_valid, resp_rdata, bus_err,
        output route_sel, wdata_out, addr_out, wstrb_out,
        output mem_en, mem_we, io_valid, io_we
    );

    // The core / target side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output mem_rdata, io_ready, io_rdata,
        input  cpu_stall, resp_valid, resp_rdata, bus_err,
        input  route_sel, wdata_out, addr_out, wstrb_out,
        input  mem_en, mem_we, io_valid, io_we
    );

endinterface

// File: rtl/lsu_route_ctrl_bus_timeout_ctr.sv
// Counts IO wait cycles; flags the cycle whose count would reach TIMEOUT.
module bus_timeout_ctr
    import lsu_route_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    // Combinational so the controller can leave IO in the TIMEOUT-th cycle itself
    assign o_expired = i_en && (r_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lsu_route_ctrl.sv
// Routes core load/stores to data memory or MMIO, stalling until the target answers.
module lsu_route_ctrl
    import lsu_route_pkg::*;
#(
    parameter logic [31:0] IO_BASE = DEF_IO_BASE,
    parameter logic [31:0] IO_MASK = DEF_IO_MASK,
    parameter int          TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    lsu_route_ctrl_if.slave  bus
);

    lsu_state_e  r_state;
    lsu_state_e  w_state_next;
    logic        r_route_sel;
    logic        r_we;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_io_data;

    logic        w_req_is_io;
    logic        w_accept;
    logic        w_expired;
    logic        w_ctr_clr;
    logic        w_ctr_en;
    logic        w_cpu_stall;
    logic        w_resp_valid;
    logic [31:0] w_resp_rdata;
    logic        w_bus_err;
    logic        w_mem_en;
    logic        w_mem_we;
    logic        w_io_valid;
    logic        w_io_we;

    assign w_req_is_io = addr_is_io(bus.req_addr, IO_BASE, IO_MASK);
    assign w_accept    = (r_state == ST_IDLE) && bus.req_valid;
    assign w_ctr_clr   = (r_state != ST_IO);
    assign w_ctr_en    = (r_state == ST_IO) && !bus.io_ready;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_ctr_clr),
        .i_en      (w_ctr_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_next = r_state;
        w_cpu_stall  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_rdata = '0;
        w_bus_err    = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_we     = 1'b0;
        w_io_valid   = 1'b0;
        w_io_we      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so every output reads 0 while reset is held
                w_cpu_stall = bus.req_valid & rst_n;
                if (bus.req_valid) begin
                    w_state_next = w_req_is_io ? ST_IO : ST_MEM;
                end
            end
            ST_MEM: begin
                w_mem_en     = 1'b1;
                w_mem_we     = r_we;
                w_cpu_stall  = 1'b1;
                w_state_next = ST_RESP;
            end
            ST_IO: begin
                w_io_valid  = 1'b1;
                w_io_we     = r_we;
                w_cpu_stall = 1'b1;
                if (bus.io_ready || w_expired) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_resp_valid = 1'b1;
                w_bus_err    = r_err;
                if (!r_we) begin
                    w_resp_rdata = r_route_sel ? r_io_data : bus.mem_rdata;
                end
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_route_sel <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_io_data   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_route_sel <= w_req_is_io;
                r_we        <= bus.req_we;
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_wstrb     <= bus.req_wstrb;
                r_err       <= 1'b0;
                r_io_data   <= '0;
            end
            if (r_state == ST_IO) begin
                // A ready arriving in the expiry cycle still wins
                if (bus.io_ready) begin
                    r_io_data <= bus.io_rdata;
                    r_err     <= 1'b0;
                end else if (w_expired) begin
                    r_io_data <= TIMEOUT_ERR_DATA;
                    r_err     <= 1'b1;
                end
            end
        end
    end

    assign bus.cpu_stall  = w_cpu_stall;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_rdata = w_resp_rdata;
    assign bus.bus_err    = w_bus_err;
    assign bus.mem_en     = w_mem_en;
    assign bus.mem_we     = w_mem_we;
    assign bus.io_valid   = w_io_valid;
    assign bus.io_we      = w_io_we;
    assign bus.route_sel  = r_route_sel;
    assign bus.addr_out   = r_addr;
    assign bus.wdata_out  = r_wdata;
    assign bus.wstrb_out  = r_wstrb;

endmodule

// File: tb/tb_lsu_route_ctrl.sv
// Directed self-checking bench for lsu_route_ctrl.
module tb_lsu_route_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   nv;

    lsu_route_ctrl_if bus ();

    lsu_route_ctrl #(
        .IO_BASE (32'h1000_0000),
        .IO_MASK (32'hF000_0000),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = wstrb;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.mem_rdata = '0;
        bus.io_ready  = 1'b0;
        bus.io_rdata  = '0;

        // Reset state
        step(); step();
        chk1 ("rst_stall",     bus.cpu_stall,  1'b0);
        chk1 ("rst_resp",      bus.resp_valid, 1'b0);
        chk1 ("rst_route",     bus.route_sel,  1'b0);
        chk1 ("rst_mem_en",    bus.mem_en,     1'b0);
        chk1 ("rst_io_valid",  bus.io_valid,   1'b0);
        chk32("rst_addr",      bus.addr_out,   32'h0);
        rst_n = 1'b1;
        step();

        // Memory load
        drive_req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        #1;
        chk1 ("mld_T_stall",   bus.cpu_stall,  1'b1);
        chk1 ("mld_T_mem_en",  bus.mem_en,     1'b0);
        step();
        chk1 ("mld_T1_mem_en", bus.mem_en,     1'b1);
        chk1 ("mld_T1_mem_we", bus.mem_we,     1'b0);
        chk1 ("mld_T1_stall",  bus.cpu_stall,  1'b1);
        chk1 ("mld_T1_route",  bus.route_sel,  1'b0);
        chk32("mld_T1_addr",   bus.addr_out,   32'h0000_0040);
        step();
        bus.req_valid = 1'b0;
        bus.mem_rdata = 32'hCAFE_F00D;
        #1;
        chk1 ("mld_T2_resp",   bus.resp_valid, 1'b1);
        chk32("mld_T2_rdata",  bus.resp_rdata, 32'hCAFE_F00D);
        chk1 ("mld_T2_stall",  bus.cpu_stall,  1'b0);
        chk1 ("mld_T2_mem_en", bus.mem_en,     1'b0);
        chk1 ("mld_T2_err",    bus.bus_err,    1'b0);
        step();
        chk1 ("mld_T3_resp",   bus.resp_valid, 1'b0);
        chk32("mld_T3_addr",   bus.addr_out,   32'h0000_0040);

        // IO store, ready at T+4
        drive_req(1'b1, 32'h1000_0008, 32'h1234_5678, 4'hF);
        #1;
        chk1 ("ios_T_stall",   bus.cpu_stall,  1'b1);
        step();
        chk1 ("ios_T1_io_v",   bus.io_valid,   1'b1);
        chk1 ("ios_T1_io_we",  bus.io_we,      1'b1);
        chk1 ("ios_T1_mem_en", bus.mem_en,     1'b0);
        chk1 ("ios_T1_route",  bus.route_sel,  1'b1);
        chk32("ios_T1_wdata",  bus.wdata_out,  32'h1234_5678);
        chk32("ios_T1_wstrb",  {28'h0, bus.wstrb_out}, 32'hF);
        step();
        chk1 ("ios_T2_io_v",   bus.io_valid,   1'b1);
        step();
        chk1 ("ios_T3_io_v",   bus.io_valid,   1'b1);
        step();
        bus.io_ready = 1'b1;
        #1;
        chk1 ("ios_T4_io_v",   bus.io_valid,   1'b1);
        chk1 ("ios_T4_resp",   bus.resp_valid, 1'b0);
        step();
        bus.io_ready  = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk1 ("ios_T5_resp",   bus.resp_valid, 1'b1);
        chk1 ("ios_T5_err",    bus.bus_err,    1'b0);
        chk32("ios_T5_rdata",  bus.resp_rdata, 32'h0);
        chk1 ("ios_T5_io_v",   bus.io_valid,   1'b0);
        step();

        // IO load timeout
        bus.io_rdata = 32'hDEAD_BEEF;
        drive_req(1'b0, 32'h1000_0100, 32'h0, 4'h0);
        step();
        nv = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (bus.io_valid) nv++;
            step();
        end
        chk32("to_io_cycles",  32'(nv),        32'd16);
        chk1 ("to_T17_resp",   bus.resp_valid, 1'b1);
        chk1 ("to_T17_err",    bus.bus_err,    1'b1);
        chk32("to_T17_rdata",  bus.resp_rdata, 32'h0);
        chk1 ("to_T17_io_v",   bus.io_valid,   1'b0);
        bus.req_valid = 1'b0;
        step();
        chk1 ("to_T18_resp",   bus.resp_valid, 1'b0);

        // Ready on the 16th IO cycle; request still high in RESP
        drive_req(1'b0, 32'h1FFF_FFFC, 32'h0, 4'h0);
        bus.io_rdata = 32'hA5A5_1234;
        step();
        for (int i = 0; i < 15; i++) step();
        bus.io_ready = 1'b1;
        #1;
        chk1 ("bnd_T16_io_v",  bus.io_valid,   1'b1);
        step();
        bus.io_ready = 1'b0;
        #1;
        chk1 ("bnd_T17_resp",  bus.resp_valid, 1'b1);
        chk1 ("bnd_T17_err",   bus.bus_err,    1'b0);
        chk32("bnd_T17_rdata", bus.resp_rdata, 32'hA5A5_1234);
        chk1 ("bnd_T17_stall", bus.cpu_stall,  1'b0);
        step();
        bus.req_valid = 1'b0;
        #1;
        chk1 ("bnd_T18_io_v",  bus.io_valid,   1'b0);
        chk1 ("bnd_T18_memen", bus.mem_en,     1'b0);
        chk1 ("bnd_T18_resp",  bus.resp_valid, 1'b0);
        step();

        // Reset in the third IO cycle
        drive_req(1'b1, 32'h1000_0010, 32'h7777_8888, 4'h5);
        step();
        step();
        step();
        chk1 ("rio_T3_io_v",   bus.io_valid,   1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("rio_io_v",      bus.io_valid,   1'b0);
        chk1 ("rio_stall",     bus.cpu_stall,  1'b0);
        chk1 ("rio_route",     bus.route_sel,  1'b0);
        chk32("rio_addr",      bus.addr_out,   32'h0);
        chk32("rio_wdata",     bus.wdata_out,  32'h0);
        chk32("rio_wstrb",     {28'h0, bus.wstrb_out}, 32'h0);
        step();
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1 ("rio_post_resp", bus.resp_valid, 1'b0);
            chk1 ("rio_post_io_v", bus.io_valid,   1'b0);
            step();
        end

        // Back-to-back: memory store then IO load
        bus.mem_rdata = 32'hFFFF_FFFF;
        drive_req(1'b1, 32'h0000_0080, 32'h55AA_55AA, 4'h3);
        step();
        chk1 ("b2b_s_mem_en",  bus.mem_en,     1'b1);
        chk1 ("b2b_s_mem_we",  bus.mem_we,     1'b1);
        chk1 ("b2b_s_route",   bus.route_sel,  1'b0);
        chk32("b2b_s_wstrb",   {28'h0, bus.wstrb_out}, 32'h3);
        chk32("b2b_s_wdata",   bus.wdata_out,  32'h55AA_55AA);
        step();
        chk1 ("b2b_s_resp",    bus.resp_valid, 1'b1);
        chk32("b2b_s_rdata",   bus.resp_rdata, 32'h0);
        chk1 ("b2b_s_err",     bus.bus_err,    1'b0);
        step();
        drive_req(1'b0, 32'h1000_0020, 32'h0, 4'h0);
        #1;
        chk1 ("b2b_l_T_route", bus.route_sel,  1'b0);
        chk1 ("b2b_l_T_stall", bus.cpu_stall,  1'b1);
        step();
        bus.io_ready = 1'b1;
        bus.io_rdata = 32'h0BAD_F00D;
        #1;
        chk1 ("b2b_l_route",   bus.route_sel,  1'b1);
        chk1 ("b2b_l_io_v",    bus.io_valid,   1'b1);
        chk1 ("b2b_l_io_we",   bus.io_we,      1'b0);
        chk32("b2b_l_addr",    bus.addr_out,   32'h1000_0020);
        step();
        bus.io_ready  = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk1 ("b2b_l_resp",    bus.resp_valid, 1'b1);
        chk32("b2b_l_rdata",   bus.resp_rdata, 32'h0BAD_F00D);
        chk1 ("b2b_l_err",     bus.bus_err,    1'b0);
        step();
        chk1 ("b2b_l_done",    bus.resp_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
